// File: rtl/line_buffer_bridge_if.sv
// Bus bundle between the core word port, the bridge and the burst memory.
// The slave modport is the bridge's view; master is the core/memory side.
interface line_buffer_bridge_if #(
    parameter int BEAT_WIDTH = 64
);
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            mem_byte_enable;
    logic [31:0]           mem_address;
    logic [31:0]           mem_wdata;
    logic                  mem_resp;
    logic [31:0]           mem_rdata;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/line_buffer_bridge.sv
// Single-line buffer between a word-wide core port and a burst-only memory.
// Reads hit in the buffered line or fetch it by burst; writes merge into the
// line and write the whole line back (write-through).
//
//   state   | meaning
//   IDLE    | wait for a core request, latch it, decide hit/miss
//   FILL    | burst-read the line, one beat per pmem_resp
//   MERGE   | merge latched write bytes into the selected word
//   WB      | burst-write the whole line back
//   RESP    | one-cycle mem_resp pulse to the core
module line_buffer_bridge #(
    parameter int BURST_LEN  = 4,
    parameter int BEAT_WIDTH = 64
) (
    input logic                 clk,
    input logic                 rst,
    line_buffer_bridge_if.slave bus
);
    localparam int LINE_W = BURST_LEN * BEAT_WIDTH;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int NWORDS = LINE_W / 32;
    localparam int CNT_W  = $clog2(BURST_LEN);
    localparam int TAG_W  = 32 - OFF;
    localparam int SEL_W  = OFF - 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_MERGE, S_WB, S_RESP} state_t;

    state_t                                state_q;
    logic                                  valid_q;
    logic [TAG_W-1:0]                      tag_q;
    logic [CNT_W-1:0]                      count_q;
    logic [BURST_LEN-1:0][BEAT_WIDTH-1:0]  line_q;
    logic [31:2]                           addr_q;
    logic [3:0]                            be_q;
    logic [31:0]                           wdata_q;
    logic                                  is_write_q;
    logic                                  mem_resp_q;
    logic [31:0]                           mem_rdata_q;
    logic                                  pmem_read_q;
    logic                                  pmem_write_q;
    logic [31:0]                           pmem_address_q;
    logic [BEAT_WIDTH-1:0]                 pmem_wdata_q;

    logic [TAG_W-1:0]                      req_tag;
    logic [SEL_W-1:0]                      word_sel;
    logic                                  hit;
    logic [NWORDS-1:0][31:0]               line_words;
    logic [BURST_LEN-1:0][BEAT_WIDTH-1:0]  fill_line_d;
    logic [NWORDS-1:0][31:0]               fill_words;
    logic [NWORDS-1:0][31:0]               merge_words;
    logic [BURST_LEN-1:0][BEAT_WIDTH-1:0]  merge_line_d;

    assign req_tag    = bus.mem_address[31:OFF];
    assign word_sel   = addr_q[OFF-1:2];
    assign hit        = valid_q && (tag_q == req_tag);
    assign line_words = line_q;
    assign fill_words = fill_line_d;
    assign merge_line_d = merge_words;

    // Line as it will look once the incoming read beat is captured; lets the
    // final beat's word be returned in the same edge that stores it.
    always_comb begin
        fill_line_d          = line_q;
        fill_line_d[count_q] = bus.pmem_rdata;
    end

    // Byte-lane merge of the latched write data into the selected word.
    always_comb begin
        merge_words = line_words;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merge_words[word_sel][i*8 +: 8] = wdata_q[i*8 +: 8];
            end
        end
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            valid_q        <= 1'b0;
            tag_q          <= '0;
            count_q        <= '0;
            line_q         <= '0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            is_write_q     <= 1'b0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            mem_resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_write || bus.mem_read) begin
                        addr_q     <= bus.mem_address[31:2];
                        be_q       <= bus.mem_byte_enable;
                        wdata_q    <= bus.mem_wdata;
                        is_write_q <= bus.mem_write;
                        if (hit && bus.mem_write) begin
                            state_q <= S_MERGE;
                        end else if (hit) begin
                            state_q     <= S_RESP;
                            mem_resp_q  <= 1'b1;
                            mem_rdata_q <= line_words[bus.mem_address[OFF-1:2]];
                        end else begin
                            state_q        <= S_FILL;
                            valid_q        <= 1'b0;
                            count_q        <= '0;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {req_tag, {OFF{1'b0}}};
                        end
                    end
                end
                S_FILL: begin
                    if (bus.pmem_resp) begin
                        line_q <= fill_line_d;
                        if (count_q == LAST_BEAT) begin
                            pmem_read_q <= 1'b0;
                            valid_q     <= 1'b1;
                            tag_q       <= addr_q[31:OFF];
                            count_q     <= '0;
                            if (is_write_q) begin
                                state_q <= S_MERGE;
                            end else begin
                                state_q     <= S_RESP;
                                mem_resp_q  <= 1'b1;
                                mem_rdata_q <= fill_words[word_sel];
                            end
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                S_MERGE: begin
                    line_q         <= merge_line_d;
                    count_q        <= '0;
                    pmem_write_q   <= 1'b1;
                    pmem_wdata_q   <= merge_line_d[0];
                    pmem_address_q <= {addr_q[31:OFF], {OFF{1'b0}}};
                    state_q        <= S_WB;
                end
                S_WB: begin
                    if (bus.pmem_resp) begin
                        if (count_q == LAST_BEAT) begin
                            pmem_write_q <= 1'b0;
                            count_q      <= '0;
                            state_q      <= S_RESP;
                            mem_resp_q   <= 1'b1;
                            mem_rdata_q  <= line_words[word_sel];
                        end else begin
                            count_q      <= count_q + 1'b1;
                            pmem_wdata_q <= line_q[count_q + 1'b1];
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_resp     = mem_resp_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
endmodule

// File: tb/tb_line_buffer_bridge.sv
// Bench for line_buffer_bridge: acts as core and burst memory, keeps a
// word-level reference memory plus a one-line buffer model, and checks
// data, latency, burst counts and pmem signalling.
module tb_line_buffer_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;

    line_buffer_bridge_if #(.BEAT_WIDTH(64)) bus ();

    line_buffer_bridge #(.BURST_LEN(4), .BEAT_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] phys    [int unsigned];   // beat-addressed physical memory
    logic [31:0] ref_mem [int unsigned];   // word-addressed expected contents

    int          gap      = 0;
    int          gap_cnt  = 0;
    int          mb       = 0;
    int          rd_beats = 0;
    int          wr_beats = 0;
    int          fill_cyc = 0;
    int          wb_cyc   = 0;
    int          last_lat = 0;
    logic        prev_resp   = 1'b0;
    logic        exp_pending = 1'b0;
    logic [31:0] exp_rdata   = '0;
    logic [31:0] exp_line    = '0;
    logic        valid_m     = 1'b0;
    logic [26:0] tag_m       = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put_beat(input int unsigned byte_addr, input logic [63:0] v);
        phys[byte_addr >> 3]          = v;
        ref_mem[byte_addr >> 2]       = v[31:0];
        ref_mem[(byte_addr >> 2) + 1] = v[63:32];
    endtask

    // Burst memory: optional idle gap before each beat, one beat per resp.
    always @(negedge clk) begin
        if (!rst) begin
            mb = 0; gap_cnt = 0; bus.pmem_resp = 1'b0;
        end else if (bus.pmem_read || bus.pmem_write) begin
            if (gap_cnt < gap) begin
                gap_cnt++;
                bus.pmem_resp = 1'b0;
            end else begin
                gap_cnt = 0;
                bus.pmem_resp = 1'b1;
                if (bus.pmem_read) begin
                    bus.pmem_rdata = phys[(bus.pmem_address >> 3) + mb];
                    rd_beats++;
                end else begin
                    phys[(bus.pmem_address >> 3) + mb] = bus.pmem_wdata;
                    wr_beats++;
                end
                mb = (mb + 1) % 4;
            end
        end else begin
            mb = 0; gap_cnt = 0; bus.pmem_resp = 1'b0;
        end
    end

    // Per-cycle compare against the reference expectations.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.pmem_read || bus.pmem_write) begin
                chk("pmem_overlap", 64'(bus.pmem_read & bus.pmem_write), 64'd0);
                chk("pmem_address", 64'(bus.pmem_address), 64'(exp_line));
            end
            if (bus.pmem_read)  fill_cyc++;
            if (bus.pmem_write) wb_cyc++;
            if (bus.mem_resp) begin
                chk("resp_expected", 64'(exp_pending), 64'd1);
                chk("mem_rdata", 64'(bus.mem_rdata), 64'(exp_rdata));
                chk("resp_one_cycle", 64'(prev_resp), 64'd0);
            end
            prev_resp = bus.mem_resp;
        end else begin
            prev_resp = 1'b0;
        end
    end

    task automatic do_tx(input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        logic        miss;
        logic [31:0] w;
        int          n;
        bit          got;
        miss = !(valid_m && tag_m == addr[31:5]);
        if (wr) begin
            w = ref_mem[addr >> 2];
            for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
            ref_mem[addr >> 2] = w;
        end
        exp_rdata = ref_mem[addr >> 2];
        exp_line  = {addr[31:5], 5'b0};
        @(posedge clk); #1;
        fill_cyc = 0; wb_cyc = 0; rd_beats = 0; wr_beats = 0;
        exp_pending         = 1'b1;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        n = 0; got = 0;
        while (!got && n < 300) begin
            @(negedge clk); #1;
            n++;
            if (bus.mem_resp) got = 1;
        end
        chk("resp_timeout", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'((wr ? 3 : 2) + fill_cyc + wb_cyc));
        chk("fill_beats", 64'(rd_beats), 64'(miss ? 4 : 0));
        chk("wb_beats", 64'(wr_beats), 64'(wr ? 4 : 0));
        last_lat = n;
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        exp_pending = 1'b0;
        valid_m = 1'b1; tag_m = addr[31:5];
    endtask

    task automatic line_check(input logic [31:0] line);
        logic [63:0] b;
        for (int w = 0; w < 8; w++) begin
            b = phys[(line >> 3) + w / 2];
            chk("wb_line_word", 64'((w % 2) ? b[63:32] : b[31:0]), 64'(ref_mem[(line >> 2) + w]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte_enable = 0;
        bus.mem_address = 0; bus.mem_wdata = 0;
        bus.pmem_rdata = 0; bus.pmem_resp = 0;

        put_beat(32'h1000, 64'h1111_0001_1111_0000);
        put_beat(32'h1008, 64'h2222_0003_1234_5678);
        put_beat(32'h1010, 64'h3333_0005_3333_0004);
        put_beat(32'h1018, 64'h4444_0007_4444_0006);
        for (int l = 2; l <= 4; l++) begin
            for (int b = 0; b < 4; b++) begin
                put_beat(l * 4096 + b * 8, {32'(l * 4096 + b * 8 + 4), 32'(l * 4096 + b * 8)});
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_mem_resp",     64'(bus.mem_resp),     64'd0);
        chk("rst_pmem_read",    64'(bus.pmem_read),    64'd0);
        chk("rst_pmem_write",   64'(bus.pmem_write),   64'd0);
        chk("rst_mem_rdata",    64'(bus.mem_rdata),    64'd0);
        chk("rst_pmem_address", 64'(bus.pmem_address), 64'd0);
        chk("rst_pmem_wdata",   bus.pmem_wdata,        64'd0);
        @(posedge clk); #1 rst = 1'b1;

        do_tx(1'b0, 32'h0000_1004, 4'h0, 32'h0);
        chk("lit_first_read", 64'(exp_rdata), 64'h1111_0001);
        chk("lit_miss_latency", 64'(last_lat), 64'd6);

        do_tx(1'b0, 32'h0000_101C, 4'h0, 32'h0);
        chk("lit_hit_read", 64'(exp_rdata), 64'h4444_0007);
        chk("lit_hit_latency", 64'(last_lat), 64'd2);

        do_tx(1'b1, 32'h0000_1008, 4'b0110, 32'hAABB_CCDD);
        chk("lit_merged_word", 64'(phys[32'h1008 >> 3][31:0]), 64'h12BB_CC78);
        chk("lit_write_hit_latency", 64'(last_lat), 64'd7);
        line_check(32'h1000);

        do_tx(1'b0, 32'h0000_1008, 4'h0, 32'h0);
        chk("lit_read_after_write", 64'(exp_rdata), 64'h12BB_CC78);

        do_tx(1'b1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF);
        chk("lit_write_miss_latency", 64'(last_lat), 64'd11);
        line_check(32'h2000);

        do_tx(1'b0, 32'h0000_1008, 4'h0, 32'h0);
        do_tx(1'b1, 32'h0000_100C, 4'b1000, 32'h5566_7788);
        chk("lit_top_byte_merge", 64'(exp_rdata), 64'h5522_0003);
        line_check(32'h1000);
        do_tx(1'b0, 32'h0000_100C, 4'h0, 32'h0);

        gap = 3;
        do_tx(1'b0, 32'h0000_4010, 4'h0, 32'h0);
        chk("lit_gap_fill_cycles", 64'(fill_cyc), 64'd16);
        chk("lit_gap_read", 64'(exp_rdata), 64'h0000_4010);
        gap = 0;

        exp_line = 32'h3000;
        @(posedge clk); #1;
        rd_beats = 0;
        bus.mem_read = 1'b1; bus.mem_address = 32'h0000_3004;
        n = 0;
        while (rd_beats < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_beat2", 64'(rd_beats), 64'd2);
        chk("abort_pre_pmem_read", 64'(bus.pmem_read), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_pmem_read_async", 64'(bus.pmem_read), 64'd0);
        chk("abort_pmem_address", 64'(bus.pmem_address), 64'd0);
        bus.mem_read = 1'b0;
        valid_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_tx(1'b0, 32'h0000_3004, 4'h0, 32'h0);
        chk("lit_refetch_beats", 64'(rd_beats), 64'd4);
        chk("lit_refetch_read", 64'(exp_rdata), 64'h0000_3004);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_buffer_bridge.md
Name: line_buffer_bridge

Overview:
- Sits between the multicycle RV32I core's word-wide memory port and a burst-only physical memory.
- Holds one line-sized buffer (tag + valid + data).
- Serves word reads from the buffer on a hit and fetches whole lines by burst on a miss.
- Writes are write-through: bytes are merged into the buffered line, then the full line is written back by burst.

Parameters:
- BURST_LEN, 4, beats per line; power of two, 2..8.
- BEAT_WIDTH, 64, bits per beat; multiple of 32.
- Derived: LINE_W = BURST_LEN*BEAT_WIDTH (256 at defaults).
- Derived: OFF = log2(LINE_W/8), the byte-offset bits (5 at defaults).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_read  in  1  core read request; held until mem_resp.
- mem_write  in  1  core write request; held until mem_resp.
- mem_byte_enable  in  4  write byte lanes; ignored for reads.
- mem_address  in  32  core byte address; bits [1:0] ignored.
- mem_wdata  in  32  core write data.
- mem_resp  out  1  one-cycle completion pulse to the core.
- mem_rdata  out  32  read data; valid while mem_resp=1.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  line-aligned burst address; bits [OFF-1:0] are 0.
- pmem_wdata  out  BEAT_WIDTH  current write beat.
- pmem_rdata  in  BEAT_WIDTH  current read beat.
- pmem_resp  in  1  per-beat acknowledge.

Behaviour:
- Reset (rst=0, async) and post-reset values:
  - State = IDLE; valid = 0; beat counter = 0.
  - mem_resp, pmem_read, pmem_write = 0; mem_rdata = 0; pmem_address = 0; pmem_wdata = 0.
  - Tag and line data are don't-care.
- Reset during a burst aborts it immediately and invalidates the buffer. The memory model is reset alongside.
- Addressing:
  - tag = mem_address[31:OFF].
  - Word select = mem_address[OFF-1:2].
  - Beat k holds line bytes [k*BEAT_WIDTH/8 +: BEAT_WIDTH/8], little-endian.
- hit = valid && (tag == stored tag).
- Requests are sampled only in IDLE.
  - mem_read and mem_write both high is illegal; write takes priority.
- States and transitions:
  - IDLE:
    - read hit -> RESP.
    - read miss -> FILL.
    - write hit -> merge -> WB.
    - write miss -> FILL.
    - no request -> stay in IDLE.
  - FILL:
    - pmem_read=1; pmem_address = {tag, OFF zeros}.
    - On each pmem_resp, capture pmem_rdata into beat[count] and increment count.
    - On the final beat: pmem_read drops the next cycle, valid=1, tag stored, count=0.
    - Then go to RESP for a read, or MERGE for a write.
    - Beats need not be consecutive; pmem_read holds steady between beats.
  - MERGE (also the write-hit path):
    - Selected word byte i <= mem_wdata byte i wherever mem_byte_enable[i]=1.
    - Single cycle; then -> WB.
  - WB:
    - pmem_write=1; pmem_wdata = beat[count].
    - Advance count on each pmem_resp.
    - After the final beat: drop pmem_write, count=0 -> RESP.
  - RESP:
    - mem_resp=1 for exactly one cycle; mem_rdata = selected word (post-merge for writes); -> IDLE.
- The core drops its request in the cycle after mem_resp. The first IDLE cycle after RESP must therefore see no request.
- pmem_read and pmem_write are never high together, and never high outside FILL and WB.
- Latency at the core port, measured from the request-present edge to the mem_resp cycle:
  - read hit: 2 cycles.
  - read miss: 2 + fill cycles.
  - write hit: 3 + WB cycles.
  - write miss: 3 + fill + WB cycles.
- The core request inputs must stay stable from acceptance until mem_resp. The bridge relatches address, byte enables and write data in IDLE and uses the latched copies thereafter.

Test Plan:
- Reset, then read 0x0000_1004; memory line 0x1000 beats = 0x..1111_0000, ... -> one FILL of 4 beats at pmem_address=0x1000, then mem_resp with mem_rdata = upper half of beat 0.
- Repeat read of 0x0000_101C with no pmem activity -> mem_resp 2 cycles after request; data = upper word of beat 3.
- Write 0x0000_1008, byte_enable=4'b0110, wdata=0xAABBCCDD over stored 0x12345678 -> WB beat 1 low word = 0x12BBCC78; other beats unchanged; next read returns 0x12BBCC78.
- Write miss to 0x0000_2000, byte_enable=4'b1111 -> FILL at 0x2000, then WB at 0x2000 with merged word; pmem_read and pmem_write never overlap.
- Memory inserts 3 idle cycles between beats -> pmem_read held high throughout; all 4 beats captured in order.
- Assert rst low mid-FILL (after beat 2) -> pmem_read=0 asynchronously; next read of the same address refetches all 4 beats.
